bp_be_fe_queue_buffer: RTL

- Backend-side receive buffer for FE queue packets emitted by the front end.
- Accepts packets with ready/valid and presents them in order to the issue stage.
- Holds every packet until the backend commits it, so issued-but-uncommitted packets can be replayed on a roll or discarded on a clear.
- Sits directly between the FE queue output and BE issue/decode.

---
 rtl/bp_be_fe_queue_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/bp_be_fe_queue_buffer.sv
// Backend receive buffer for FE queue packets.
// Packets are issued speculatively through a read pointer and retired through a
// checkpoint pointer. Uncommitted packets can be replayed on a roll or flushed
// on a clear.
module bp_be_fe_queue_buffer #(
    parameter int unsigned fe_queue_width_p = 128,
    parameter int unsigned els_p            = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [fe_queue_width_p-1:0] fe_queue_i,
    input  logic                        fe_queue_v_i,
    output logic                        fe_queue_ready_o,

    output logic [fe_queue_width_p-1:0] fe_queue_o,
    output logic                        fe_queue_v_o,
    input  logic                        fe_queue_yumi_i,

    input  logic                        deq_v_i,
    input  logic                        roll_v_i,
    input  logic                        clr_v_i,
    output logic                        empty_o
);

    localparam int unsigned idx_width_lp = $clog2(els_p);
    // Index bits plus one wrap bit to tell full from empty.
    localparam int unsigned ptr_width_lp = idx_width_lp + 1;

    localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

    logic [fe_queue_width_p-1:0] mem_q [els_p];

    logic [ptr_width_lp-1:0] wptr_d, wptr_q;
    logic [ptr_width_lp-1:0] rptr_d, rptr_q;
    logic [ptr_width_lp-1:0] cptr_d, cptr_q;

    logic full;
    logic enq_v;
    logic yumi_v;

    // Status outputs come from registered pointers only; occupancy counts from
    // the checkpoint so issued-but-uncommitted packets still hold their slot.
    always_comb begin
        full = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
             & (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0]);
        fe_queue_ready_o = ~full;
        fe_queue_v_o     = (rptr_q != wptr_q);
        empty_o          = (cptr_q == wptr_q);
        fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];
    end

    // Next-state pointers; clear beats roll beats issue, and an enqueue that
    // coincides with a clear is dropped.
    always_comb begin
        enq_v  = fe_queue_v_i & fe_queue_ready_o & ~clr_v_i;
        yumi_v = fe_queue_yumi_i & fe_queue_v_o;

        wptr_d = enq_v ? (wptr_q + ptr_one_lp) : wptr_q;

        if (clr_v_i) begin
            cptr_d = wptr_q;
        end else if (deq_v_i) begin
            cptr_d = cptr_q + ptr_one_lp;
        end else begin
            cptr_d = cptr_q;
        end

        // Roll uses the post-deq checkpoint so replay skips a same-cycle commit.
        if (clr_v_i) begin
            rptr_d = wptr_q;
        end else if (roll_v_i) begin
            rptr_d = cptr_d;
        end else if (yumi_v) begin
            rptr_d = rptr_q + ptr_one_lp;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Packet storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (enq_v) begin
            mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    // Committing a packet that has not been issued yet.
    a_deq_unissued : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_v_i && (cptr_q == rptr_q)));

    // Consuming when nothing is presented.
    a_yumi_invalid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fe_queue_yumi_i && !fe_queue_v_o));
`endif

endmodule
